// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending controller: FSM states,
// one-hot coin encodings, denomination values and greedy change selection.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGIT2,
    ST_CHECK,
    ST_VEND,
    ST_CHANGE
  } state_t;

  localparam logic [4:0] COIN_5   = 5'b00001;
  localparam logic [4:0] COIN_10  = 5'b00010;
  localparam logic [4:0] COIN_20  = 5'b00100;
  localparam logic [4:0] COIN_50  = 5'b01000;
  localparam logic [4:0] COIN_100 = 5'b10000;

  localparam int unsigned DENOM_5   = 5;
  localparam int unsigned DENOM_10  = 10;
  localparam int unsigned DENOM_20  = 20;
  localparam int unsigned DENOM_50  = 50;
  localparam int unsigned DENOM_100 = 100;

  // Non-one-hot patterns map to zero so callers never credit a malformed coin.
  function automatic int unsigned coin_value(input logic [4:0] c);
    case (c)
      COIN_5:   return DENOM_5;
      COIN_10:  return DENOM_10;
      COIN_20:  return DENOM_20;
      COIN_50:  return DENOM_50;
      COIN_100: return DENOM_100;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [4:0] greedy_coin(input int unsigned amount);
    if (amount >= DENOM_100) return COIN_100;
    if (amount >= DENOM_50)  return COIN_50;
    if (amount >= DENOM_20)  return COIN_20;
    if (amount >= DENOM_10)  return COIN_10;
    if (amount >= DENOM_5)   return COIN_5;
    return 5'b00000;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Bus between the vending core and the keypad / coin / restock front end
// (master) and the dispense / coin-return actuators.
interface vend_if #(
  parameter int NUM_PRODUCTS = 10,
  parameter int PRICE_W      = 8,
  parameter int CREDIT_W     = 8,
  parameter int QTY_W        = 4
);
  logic                            coin_valid;
  logic [4:0]                      coin;
  logic                            sel_valid;
  logic [3:0]                      sel_code;
  logic                            cancel;
  logic [NUM_PRODUCTS*PRICE_W-1:0] price_of_all;
  logic                            restock_valid;
  logic [6:0]                      restock_prod;
  logic [QTY_W-1:0]                restock_qty;

  logic                            coin_accept;
  logic                            coin_reject;
  logic [CREDIT_W-1:0]             credit;
  logic                            vend_pulse;
  logic [6:0]                      vend_prod;
  logic                            change_valid;
  logic [4:0]                      change_coin;
  logic                            err_sel;
  logic                            err_stock;
  logic                            err_funds;
  logic                            busy;

  modport master (
    output coin_valid, coin, sel_valid, sel_code, cancel, price_of_all,
           restock_valid, restock_prod, restock_qty,
    input  coin_accept, coin_reject, credit, vend_pulse, vend_prod,
           change_valid, change_coin, err_sel, err_stock, err_funds, busy
  );

  modport slave (
    input  coin_valid, coin, sel_valid, sel_code, cancel, price_of_all,
           restock_valid, restock_prod, restock_qty,
    output coin_accept, coin_reject, credit, vend_pulse, vend_prod,
           change_valid, change_coin, err_sel, err_stock, err_funds, busy
  );
endinterface

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with a restock write, a single decrement port
// and a combinational read port; restock beats decrement on the same slot.
module vend_stock_bank #(
  parameter int NUM_PRODUCTS = 10,
  parameter int QTY_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restock_valid,
  input  logic [6:0]       restock_prod,
  input  logic [QTY_W-1:0] restock_qty,
  input  logic             dec_valid,
  input  logic [6:0]       dec_prod,
  input  logic [6:0]       rd_prod,
  output logic [QTY_W-1:0] rd_qty
);

  logic [QTY_W-1:0]        stock_reg  [NUM_PRODUCTS];
  logic [QTY_W-1:0]        stock_next [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] hit_restock;
  logic [NUM_PRODUCTS-1:0] hit_dec;

  // Products are numbered from 1, so slot gi holds product gi+1.
  generate
    for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_slot
      assign hit_restock[gi] = restock_valid && (restock_prod == 7'(gi + 1));
      assign hit_dec[gi]     = dec_valid && (dec_prod == 7'(gi + 1)) && (stock_reg[gi] != '0);
      assign stock_next[gi]  = hit_restock[gi] ? restock_qty :
                               hit_dec[gi]     ? stock_reg[gi] - QTY_W'(1) :
                                                 stock_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PRODUCTS; i++) stock_reg[i] <= '0;
    end else begin
      stock_reg <= stock_next;
    end
  end

  always_comb begin
    rd_qty = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (rd_prod == 7'(i + 1)) rd_qty = stock_reg[i];
    end
  end

endmodule

// File: rtl/vend_core.sv
// Vending controller: coin credit, two-digit selection, range/stock/funds
// check, vend strobe and greedy one-coin-per-cycle change or refund.
module vend_core
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 10,
  parameter int PRICE_W      = 8,
  parameter int CREDIT_W     = 8,
  parameter int QTY_W        = 4,
  parameter int MAX_CREDIT   = 250
) (
  input logic   clk,
  input logic   reset,
  vend_if.slave bus
);

  state_t              state_reg, state_next;
  logic [3:0]          d1_reg, d1_next;
  logic [3:0]          d2_reg, d2_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                coin_accept_reg, coin_accept_next;
  logic                coin_reject_reg, coin_reject_next;
  logic                vend_pulse_reg, vend_pulse_next;
  logic [6:0]          vend_prod_reg, vend_prod_next;
  logic                change_valid_reg, change_valid_next;
  logic [4:0]          change_coin_reg, change_coin_next;
  logic                err_sel_reg, err_sel_next;
  logic                err_stock_reg, err_stock_next;
  logic                err_funds_reg, err_funds_next;
  logic                busy_reg;

  logic [PRICE_W-1:0]  price_arr [NUM_PRODUCTS];
  logic [PRICE_W-1:0]  price_sel;
  logic [QTY_W-1:0]    stock_qty;
  logic [7:0]          p_full;
  logic [6:0]          prod;
  logic                sel_bad, stock_empty, funds_low;
  logic                entry_state, coin_ok, can_change, dec_valid;
  logic [4:0]          greedy;

  generate
    for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_price
      assign price_arr[gi] = bus.price_of_all[gi*PRICE_W +: PRICE_W];
    end
  endgenerate

  // Eight bits so that out-of-range keypad codes cannot alias into range.
  assign p_full      = 8'(d1_reg) * 8'd10 + 8'(d2_reg);
  assign prod        = p_full[6:0];
  assign sel_bad     = (p_full == 8'd0) || (32'(p_full) > 32'(NUM_PRODUCTS));
  assign stock_empty = (stock_qty == '0);
  assign funds_low   = 32'(credit_reg) < 32'(price_sel);
  assign entry_state = (state_reg == ST_IDLE) || (state_reg == ST_DIGIT2);
  assign coin_ok     = $onehot(bus.coin) &&
                       (32'(credit_reg) + coin_value(bus.coin) <= 32'(MAX_CREDIT));
  assign can_change  = 32'(credit_reg) >= DENOM_5;
  assign greedy      = greedy_coin(32'(credit_reg));

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (32'(prod) == 32'(i + 1)) price_sel = price_arr[i];
    end
  end

  vend_stock_bank #(
    .NUM_PRODUCTS(NUM_PRODUCTS),
    .QTY_W       (QTY_W)
  ) u_stock (
    .clk          (clk),
    .reset        (reset),
    .restock_valid(bus.restock_valid),
    .restock_prod (bus.restock_prod),
    .restock_qty  (bus.restock_qty),
    .dec_valid    (dec_valid),
    .dec_prod     (prod),
    .rd_prod      (prod),
    .rd_qty       (stock_qty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      d1_reg           <= '0;
      d2_reg           <= '0;
      credit_reg       <= '0;
      coin_accept_reg  <= 1'b0;
      coin_reject_reg  <= 1'b0;
      vend_pulse_reg   <= 1'b0;
      vend_prod_reg    <= '0;
      change_valid_reg <= 1'b0;
      change_coin_reg  <= '0;
      err_sel_reg      <= 1'b0;
      err_stock_reg    <= 1'b0;
      err_funds_reg    <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      d1_reg           <= d1_next;
      d2_reg           <= d2_next;
      credit_reg       <= credit_next;
      coin_accept_reg  <= coin_accept_next;
      coin_reject_reg  <= coin_reject_next;
      vend_pulse_reg   <= vend_pulse_next;
      vend_prod_reg    <= vend_prod_next;
      change_valid_reg <= change_valid_next;
      change_coin_reg  <= change_coin_next;
      err_sel_reg      <= err_sel_next;
      err_stock_reg    <= err_stock_next;
      err_funds_reg    <= err_funds_next;
      busy_reg         <= (state_next == ST_CHECK) || (state_next == ST_VEND) ||
                          (state_next == ST_CHANGE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.cancel)         state_next = ST_CHANGE;
        else if (bus.sel_valid) state_next = ST_DIGIT2;
      end
      ST_DIGIT2: begin
        if (bus.cancel)         state_next = ST_CHANGE;
        else if (bus.sel_valid) state_next = ST_CHECK;
      end
      ST_CHECK:  state_next = (sel_bad || stock_empty || funds_low) ? ST_IDLE : ST_VEND;
      ST_VEND:   state_next = can_change ? ST_CHANGE : ST_IDLE;
      ST_CHANGE: state_next = can_change ? ST_CHANGE : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    d1_next           = d1_reg;
    d2_next           = d2_reg;
    credit_next       = credit_reg;
    coin_accept_next  = 1'b0;
    coin_reject_next  = 1'b0;
    vend_pulse_next   = 1'b0;
    vend_prod_next    = vend_prod_reg;
    change_valid_next = 1'b0;
    change_coin_next  = '0;
    err_sel_next      = 1'b0;
    err_stock_next    = 1'b0;
    err_funds_next    = 1'b0;
    dec_valid         = 1'b0;

    if (bus.coin_valid) begin
      if (entry_state && coin_ok) begin
        coin_accept_next = 1'b1;
        credit_next      = CREDIT_W'(32'(credit_reg) + coin_value(bus.coin));
      end else begin
        coin_reject_next = 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE, ST_DIGIT2: begin
        if (bus.cancel) begin
          d1_next = '0;
          d2_next = '0;
        end else if (bus.sel_valid) begin
          if (state_reg == ST_IDLE) d1_next = bus.sel_code;
          else                      d2_next = bus.sel_code;
        end
      end
      ST_CHECK: begin
        d1_next = '0;
        d2_next = '0;
        if (sel_bad)          err_sel_next   = 1'b1;
        else if (stock_empty) err_stock_next = 1'b1;
        else if (funds_low)   err_funds_next = 1'b1;
        else begin
          credit_next     = CREDIT_W'(32'(credit_reg) - 32'(price_sel));
          dec_valid       = 1'b1;
          vend_pulse_next = 1'b1;
          vend_prod_next  = prod;
        end
      end
      // Both states pay out one greedy coin per cycle from the current credit.
      ST_VEND, ST_CHANGE: begin
        if (can_change) begin
          change_valid_next = 1'b1;
          change_coin_next  = greedy;
          credit_next       = CREDIT_W'(32'(credit_reg) - coin_value(greedy));
        end
      end
      default: ;
    endcase
  end

  assign bus.coin_accept  = coin_accept_reg;
  assign bus.coin_reject  = coin_reject_reg;
  assign bus.credit       = credit_reg;
  assign bus.vend_pulse   = vend_pulse_reg;
  assign bus.vend_prod    = vend_prod_reg;
  assign bus.change_valid = change_valid_reg;
  assign bus.change_coin  = change_coin_reg;
  assign bus.err_sel      = err_sel_reg;
  assign bus.err_stock    = err_stock_reg;
  assign bus.err_funds    = err_funds_reg;
  assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_vend_core.sv
// Scoreboard bench for vend_core: stimulus queues expected output events,
// a negedge monitor pops and compares them; timing-critical points are checked inline.
module tb_vend_core;
  localparam int NP = 10;
  localparam int PW = 8;
  localparam int CW = 8;
  localparam int QW = 4;
  localparam int MC = 250;

  typedef enum int {EV_ACC, EV_REJ, EV_VEND, EV_ESEL, EV_ESTK, EV_EFUN, EV_CHG} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ev_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vend_if #(.NUM_PRODUCTS(NP), .PRICE_W(PW), .CREDIT_W(CW), .QTY_W(QW)) bus ();

  vend_core #(
    .NUM_PRODUCTS(NP), .PRICE_W(PW), .CREDIT_W(CW), .QTY_W(QW), .MAX_CREDIT(MC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic expect_ev(input ev_kind_t k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic got_ev(input ev_kind_t k, input int v);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event actual=%s/%0d required=none", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL event actual=%s/%0d required=%s/%0d", k.name(), v, e.kind.name(), e.val);
      end else begin
        $display("[TB] event %s %0d at %0t", k.name(), v, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.coin_accept)  got_ev(EV_ACC, 0);
    if (bus.coin_reject)  got_ev(EV_REJ, 0);
    if (bus.vend_pulse)   got_ev(EV_VEND, int'(bus.vend_prod));
    if (bus.err_sel)      got_ev(EV_ESEL, 0);
    if (bus.err_stock)    got_ev(EV_ESTK, 0);
    if (bus.err_funds)    got_ev(EV_EFUN, 0);
    if (bus.change_valid) got_ev(EV_CHG, int'(bus.change_coin));
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin_in(input logic [4:0] c, input bit ok);
    if (ok) expect_ev(EV_ACC, 0);
    else    expect_ev(EV_REJ, 0);
    bus.coin_valid = 1'b1;
    bus.coin       = c;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin       = '0;
  endtask

  task automatic key(input int d);
    bus.sel_valid = 1'b1;
    bus.sel_code  = 4'(d);
    tick();
    bus.sel_valid = 1'b0;
    bus.sel_code  = '0;
  endtask

  task automatic cancel_req();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  task automatic restock(input int p, input int q);
    bus.restock_valid = 1'b1;
    bus.restock_prod  = 7'(p);
    bus.restock_qty   = 4'(q);
    tick();
    bus.restock_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NP*PW-1:0] prices;
    int refund185 [5];
    refund185 = '{16, 8, 4, 2, 1};
    for (int k = 1; k <= NP; k++) prices[(k-1)*PW +: PW] = 8'd10;
    prices[2*PW +: PW] = 8'd45;
    prices[3*PW +: PW] = 8'd45;
    prices[4*PW +: PW] = 8'd50;
    bus.price_of_all  = prices;
    bus.coin_valid    = 1'b0;
    bus.coin          = '0;
    bus.sel_valid     = 1'b0;
    bus.sel_code      = '0;
    bus.cancel        = 1'b0;
    bus.restock_valid = 1'b0;
    bus.restock_prod  = '0;
    bus.restock_qty   = '0;

    tick(2);
    reset = 1'b0;
    chk("reset_credit", int'(bus.credit), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_vend_prod", int'(bus.vend_prod), 0);
    chk("reset_change_coin", int'(bus.change_coin), 0);
    tick();

    // Basic vend with change 20 then 5
    restock(3, 2);
    coin_in(5'b01000, 1);
    coin_in(5'b00100, 1);
    chk("credit_70", int'(bus.credit), 70);
    expect_ev(EV_VEND, 3);
    expect_ev(EV_CHG, 16'h4);
    expect_ev(EV_CHG, 16'h1);
    key(0);
    key(3);
    chk("check_busy", int'(bus.busy), 1);
    tick();
    chk("vend_at_t2", int'(bus.vend_pulse), 1);
    chk("vend_prod_3", int'(bus.vend_prod), 3);
    chk("credit_after_vend", int'(bus.credit), 25);
    tick();
    chk("change_at_t3", int'(bus.change_valid), 1);
    chk("change_20", int'(bus.change_coin), 4);
    tick(3);
    chk("credit_after_change", int'(bus.credit), 0);
    chk("idle_busy", int'(bus.busy), 0);

    // Stock 1 left: exact-price vend, then err_stock
    coin_in(5'b00100, 1);
    coin_in(5'b00100, 1);
    coin_in(5'b00001, 1);
    expect_ev(EV_VEND, 3);
    key(0); key(3); tick(3);
    chk("credit_exact_vend", int'(bus.credit), 0);
    coin_in(5'b01000, 1);
    expect_ev(EV_ESTK, 0);
    key(0); key(3); tick(2);
    chk("credit_after_estk", int'(bus.credit), 50);
    expect_ev(EV_CHG, 8);
    cancel_req(); tick(4);

    // Coin rejection and credit ceiling
    coin_in(5'b00011, 0);
    chk("credit_bad_coin", int'(bus.credit), 0);
    coin_in(5'b10000, 1);
    coin_in(5'b10000, 1);
    coin_in(5'b10000, 0);
    chk("credit_200_held", int'(bus.credit), 200);
    coin_in(5'b01000, 1);
    chk("credit_at_max", int'(bus.credit), 250);
    coin_in(5'b00001, 0);
    chk("credit_max_held", int'(bus.credit), 250);
    expect_ev(EV_CHG, 16); expect_ev(EV_CHG, 16); expect_ev(EV_CHG, 8);
    cancel_req(); tick(6);
    chk("credit_refunded", int'(bus.credit), 0);

    // Selection / stock / funds errors keep credit
    coin_in(5'b00100, 1);
    expect_ev(EV_ESEL, 0);
    key(1); key(2); tick(2);
    chk("credit_after_esel", int'(bus.credit), 20);
    expect_ev(EV_ESEL, 0);
    key(0); key(0); tick(2);
    expect_ev(EV_ESTK, 0);
    key(1); key(0); tick(2);
    coin_in(5'b00010, 1);
    expect_ev(EV_ESTK, 0);
    key(0); key(4); tick(2);
    restock(4, 1);
    restock(11, 5);
    expect_ev(EV_EFUN, 0);
    key(0); key(4); tick(2);
    chk("credit_after_efun", int'(bus.credit), 30);
    expect_ev(EV_ESEL, 0);
    key(1); key(1); tick(2);
    expect_ev(EV_CHG, 4); expect_ev(EV_CHG, 2);
    cancel_req(); tick(4);

    // Cancel beats a same-cycle digit; full greedy refund of 185
    coin_in(5'b10000, 1); coin_in(5'b01000, 1); coin_in(5'b00100, 1);
    coin_in(5'b00010, 1); coin_in(5'b00001, 1);
    chk("credit_185", int'(bus.credit), 185);
    key(1);
    for (int i = 0; i < 5; i++) expect_ev(EV_CHG, refund185[i]);
    bus.sel_valid = 1'b1; bus.sel_code = 4'd2; bus.cancel = 1'b1;
    tick();
    bus.sel_valid = 1'b0; bus.sel_code = '0; bus.cancel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("refund_consecutive", int'(bus.change_valid), 1);
      chk("refund_coin", int'(bus.change_coin), refund185[i]);
    end
    tick(2);
    chk("credit_after_refund", int'(bus.credit), 0);

    // Restock on the same cycle as a decrement wins
    restock(5, 1);
    coin_in(5'b01000, 1);
    expect_ev(EV_VEND, 5);
    key(0); key(5);
    bus.restock_valid = 1'b1; bus.restock_prod = 7'd5; bus.restock_qty = 4'd1;
    tick();
    bus.restock_valid = 1'b0;
    tick(2);
    coin_in(5'b01000, 1);
    expect_ev(EV_VEND, 5);
    key(0); key(5); tick(3);
    coin_in(5'b01000, 1);
    expect_ev(EV_ESTK, 0);
    key(0); key(5); tick(2);
    expect_ev(EV_CHG, 8);
    cancel_req(); tick(4);

    // Reset in the middle of a refund
    restock(3, 5);
    coin_in(5'b10000, 1); coin_in(5'b01000, 1); coin_in(5'b00100, 1);
    coin_in(5'b00010, 1); coin_in(5'b00001, 1);
    expect_ev(EV_CHG, 16); expect_ev(EV_CHG, 8);
    cancel_req();
    tick(2);
    reset = 1'b1;
    tick();
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_change_valid", int'(bus.change_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    tick(2);
    chk("rst_credit_stays", int'(bus.credit), 0);
    coin_in(5'b01000, 1);
    expect_ev(EV_ESTK, 0);
    key(0); key(3); tick(2);
    expect_ev(EV_CHG, 8);
    cancel_req(); tick(5);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_core.md
# vend_core

Parametrised vending controller for the vending machine top level, replacing the separate credit, price, stock and refund blocks with one single-clock engine. Accepts one-hot coins with a saturating credit limit, takes a two-digit product selection from the keypad scanner and checks range, stock and funds. It then vends, and pays change or refunds one coin per cycle by greedy denomination. It sits between the keypad scanner/coin acceptor and the dispense/coin-return actuators.

## Interface
- NUM_PRODUCTS, 10, number of product slots, range 1..99
- PRICE_W, 8, price width in rupees
- CREDIT_W, 8, credit register width
- QTY_W, 4, per-product stock counter width
- MAX_CREDIT, 250, highest credit accepted; must be ≤ 2^CREDIT_W−1

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- coin_valid  in  1  one-cycle strobe, coin present
- coin  in  5  one-hot: bit0=5, bit1=10, bit2=20, bit3=50, bit4=100
- sel_valid  in  1  one-cycle strobe, keypad digit present
- sel_code  in  4  decimal digit 0..9
- cancel  in  1  refund request
- price_of_all  in  NUM_PRODUCTS*PRICE_W  price of product k at [(k−1)*PRICE_W +: PRICE_W]
- restock_valid  in  1  load stock strobe
- restock_prod  in  7  product number 1..NUM_PRODUCTS
- restock_qty  in  QTY_W  new stock count
- coin_accept / coin_reject  out  1  one-cycle pulses
- credit  out  CREDIT_W  current credit
- vend_pulse  out  1  one-cycle dispense strobe
- vend_prod  out  7  product dispensed, valid with vend_pulse
- change_valid  out  1  one coin returned this cycle
- change_coin  out  5  one-hot coin returned, same encoding as coin
- err_sel / err_stock / err_funds  out  1  one-cycle error pulses
- busy  out  1  high in CHECK, VEND, CHANGE

## Operation
- States: IDLE, DIGIT2, CHECK, VEND, CHANGE.
- Coins are processed in IDLE and DIGIT2 only.
  - Accept when coin is exactly one-hot and credit+value ≤ MAX_CREDIT. Credit updates next cycle and coin_accept pulses.
  - Otherwise coin_reject pulses and credit is unchanged.
  - Coins in CHECK/VEND/CHANGE are always rejected.
- IDLE: sel_valid latches d1 → DIGIT2. DIGIT2: sel_valid latches d2 → CHECK.
- cancel in IDLE/DIGIT2 goes to CHANGE and clears digits. cancel wins over a same-cycle sel_valid. cancel in other states is ignored.
- CHECK lasts one cycle, with p = d1*10+d2, evaluated in priority order:
  - p==0 or p>NUM_PRODUCTS → err_sel, then IDLE.
  - stock[p]==0 → err_stock, then IDLE.
  - credit<price[p] → err_funds, then IDLE.
  - In every error case credit is retained.
  - Otherwise credit −= price[p], stock[p] −= 1, then VEND.
- VEND: vend_pulse and vend_prod=p. Go to CHANGE if credit ≥ 5, else IDLE.
- CHANGE: each cycle emit the largest denomination ≤ credit and subtract it. Go to IDLE when credit < 5; a remainder < 5 stays in credit.
- Restock is accepted in any state and sets stock[restock_prod]=restock_qty. Out-of-range restock_prod is ignored. A restock of the product being decremented in the same cycle wins: the final value is restock_qty.
- Coin and sel_valid in the same IDLE cycle are both processed.

## Timing
- All outputs are registered.
- Reset values: state IDLE, credit 0, every stock 0, digits 0, all pulses/valids 0, change_coin 0, vend_prod 0.
- sel_valid for d2 at cycle t gives CHECK at t+1, vend_pulse or error at t+2, first change_valid at t+3, then consecutive coins on consecutive cycles.
- Coin at cycle t gives coin_accept/reject and updated credit at t+1.
- Reset at any point, including mid-CHANGE, returns everything to reset values on the next edge. Coins not yet emitted are lost.

## Structure
- Shared package vend_pkg: state enum, one-hot coin encodings, denomination values 5/10/20/50/100, greedy-select function.
- Sub-module vend_stock_bank: NUM_PRODUCTS×QTY_W counters with restock write, decrement, read port and restock priority.

## Test plan
- 50,20 inserted (credit 70); stock[3]=2, price 45; keys 0,3 → vend_pulse with prod 3 at t+2, credit 25, change coins 20 then 5, credit 0, stock[3]=1.
- coin 5'b00011 → coin_reject, credit unchanged; with credit 200, insert 100 → coin_reject, credit stays 200.
- keys 1,2 with NUM_PRODUCTS=10 → err_sel, credit retained, no vend.
- stock[4]=0 → err_stock; credit 30 with price 45 → err_funds, credit stays 30.
- credit 185, key 1 then cancel → change 100,50,20,10,5 on five consecutive cycles, credit 0.
- reset during CHANGE → next cycle credit 0, change_valid 0, all stock 0, state IDLE.
